// File: rtl/switch_mcu_regfile.sv
// Integer register file x0..x31: two registered read ports with write-through bypass,
// one write port, and a combinational debug read port. 1-cycle read latency; no backpressure.
module switch_mcu_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_ren_1,
    input  logic [ADDR_W-1:0] in_raddr_1,
    output logic [DATA_W-1:0] out_rdata_1,
    output logic              out_rvalid_1,
    input  logic              in_ren_2,
    input  logic [ADDR_W-1:0] in_raddr_2,
    output logic [DATA_W-1:0] out_rdata_2,
    output logic              out_rvalid_2,
    input  logic              in_wen,
    input  logic [ADDR_W-1:0] in_waddr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [ADDR_W-1:0] in_dbg_addr,
    output logic [DATA_W-1:0] out_dbg_data,
    output logic              out_x0_wr
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] rdata_1_q, rdata_1_d;
    logic [DATA_W-1:0] rdata_2_q, rdata_2_d;
    logic              rvalid_1_q, rvalid_2_q;
    logic              x0_wr_q;
    logic              wr_commit;

    assign wr_commit = in_wen && (in_waddr != '0);

    // Same-edge write to the read address returns the new value.
    always_comb begin
        rdata_1_d = rdata_1_q;
        if (in_ren_1) begin
            if (in_raddr_1 == '0)
                rdata_1_d = '0;
            else if (wr_commit && (in_waddr == in_raddr_1))
                rdata_1_d = in_wdata;
            else
                rdata_1_d = regs_q[in_raddr_1];
        end
    end

    always_comb begin
        rdata_2_d = rdata_2_q;
        if (in_ren_2) begin
            if (in_raddr_2 == '0)
                rdata_2_d = '0;
            else if (wr_commit && (in_waddr == in_raddr_2))
                rdata_2_d = in_wdata;
            else
                rdata_2_d = regs_q[in_raddr_2];
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
            rdata_1_q  <= '0;
            rdata_2_q  <= '0;
            rvalid_1_q <= 1'b0;
            rvalid_2_q <= 1'b0;
            x0_wr_q    <= 1'b0;
        end else begin
            if (wr_commit)
                regs_q[in_waddr] <= in_wdata;
            rdata_1_q  <= rdata_1_d;
            rdata_2_q  <= rdata_2_d;
            rvalid_1_q <= in_ren_1;
            rvalid_2_q <= in_ren_2;
            x0_wr_q    <= in_wen && (in_waddr == '0);
        end
    end

    assign out_rdata_1  = rdata_1_q;
    assign out_rvalid_1 = rvalid_1_q;
    assign out_rdata_2  = rdata_2_q;
    assign out_rvalid_2 = rvalid_2_q;
    assign out_x0_wr    = x0_wr_q;
    assign out_dbg_data = (in_dbg_addr == '0) ? '0 : regs_q[in_dbg_addr];

endmodule

// File: tb/tb_switch_mcu_regfile.sv
// Directed bench for switch_mcu_regfile with immediate-assertion checks.
module tb_switch_mcu_regfile;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_ren_1, in_ren_2, in_wen;
    logic [4:0]  in_raddr_1, in_raddr_2, in_waddr, in_dbg_addr;
    logic [31:0] in_wdata;
    logic [31:0] out_rdata_1, out_rdata_2, out_dbg_data;
    logic        out_rvalid_1, out_rvalid_2, out_x0_wr;

    int n_checks = 0;
    int n_fail   = 0;

    switch_mcu_regfile dut (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .in_ren_1     (in_ren_1),
        .in_raddr_1   (in_raddr_1),
        .out_rdata_1  (out_rdata_1),
        .out_rvalid_1 (out_rvalid_1),
        .in_ren_2     (in_ren_2),
        .in_raddr_2   (in_raddr_2),
        .out_rdata_2  (out_rdata_2),
        .out_rvalid_2 (out_rvalid_2),
        .in_wen       (in_wen),
        .in_waddr     (in_waddr),
        .in_wdata     (in_wdata),
        .in_dbg_addr  (in_dbg_addr),
        .out_dbg_data (out_dbg_data),
        .out_x0_wr    (out_x0_wr)
    );

    always #5 in_clk = ~in_clk;

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic dbg(input logic [4:0] a, input logic [31:0] exp, input string tag);
        in_dbg_addr = a;
        #1;
        chk(tag, out_dbg_data, exp);
    endtask

    initial begin
        in_rst = 1'b0;
        in_ren_1 = 0; in_ren_2 = 0; in_wen = 0;
        in_raddr_1 = 0; in_raddr_2 = 0; in_waddr = 0; in_dbg_addr = 0;
        in_wdata = 0;

        // 1. Reset
        #2;
        chk("rst_rdata_1",  out_rdata_1, 32'h0);
        chk("rst_rdata_2",  out_rdata_2, 32'h0);
        chk("rst_rvalid_1", {31'b0, out_rvalid_1}, 32'h0);
        chk("rst_rvalid_2", {31'b0, out_rvalid_2}, 32'h0);
        chk("rst_x0_wr",    {31'b0, out_x0_wr}, 32'h0);
        tick();
        tick();
        in_rst = 1'b1;
        tick();
        chk("post_rst_rvalid_1", {31'b0, out_rvalid_1}, 32'h0);
        for (int a = 1; a < 32; a++)
            dbg(a[4:0], 32'h0, $sformatf("rst_dbg_x%0d", a));

        // 2. Basic write/read and hold
        in_wen = 1; in_waddr = 5; in_wdata = 32'hDEADBEEF;
        tick();
        in_wen = 0;
        in_ren_1 = 1; in_raddr_1 = 5;
        tick();
        in_ren_1 = 0;
        chk("rd_x5_data",   out_rdata_1, 32'hDEADBEEF);
        chk("rd_x5_valid",  {31'b0, out_rvalid_1}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("hold_x5_data_%0d", k),  out_rdata_1, 32'hDEADBEEF);
            chk($sformatf("hold_x5_valid_%0d", k), {31'b0, out_rvalid_1}, 32'h0);
        end

        // 3. x0 write discarded
        in_ren_1 = 1; in_raddr_1 = 5; in_ren_2 = 1; in_raddr_2 = 5;
        tick();
        chk("pre_x0_p2", out_rdata_2, 32'hDEADBEEF);
        in_ren_1 = 0; in_ren_2 = 0;
        in_wen = 1; in_waddr = 0; in_wdata = 32'h1234;
        tick();
        in_wen = 0;
        chk("x0_wr_pulse", {31'b0, out_x0_wr}, 32'h1);
        tick();
        chk("x0_wr_clear", {31'b0, out_x0_wr}, 32'h0);
        in_ren_1 = 1; in_raddr_1 = 0; in_ren_2 = 1; in_raddr_2 = 0;
        tick();
        in_ren_1 = 0; in_ren_2 = 0;
        chk("rd_x0_p1", out_rdata_1, 32'h0);
        chk("rd_x0_p2", out_rdata_2, 32'h0);
        chk("rd_x0_v2", {31'b0, out_rvalid_2}, 32'h1);
        dbg(5'd0, 32'h0, "dbg_x0");

        // 4. Write-through bypass
        in_wen = 1; in_waddr = 7; in_wdata = 32'h1;
        tick();
        in_wen = 1; in_waddr = 7; in_wdata = 32'h9;
        in_ren_1 = 1; in_raddr_1 = 7; in_ren_2 = 1; in_raddr_2 = 7;
        dbg(5'd7, 32'h1, "dbg_x7_before");
        tick();
        in_wen = 0; in_ren_1 = 0; in_ren_2 = 0;
        chk("byp_p1", out_rdata_1, 32'h9);
        chk("byp_p2", out_rdata_2, 32'h9);
        dbg(5'd7, 32'h9, "dbg_x7_after");

        // 5. EX-unit add sequence
        in_wen = 1; in_waddr = 1; in_wdata = 32'h3;
        tick();
        in_waddr = 2; in_wdata = 32'h4;
        tick();
        in_wen = 0;
        in_ren_1 = 1; in_raddr_1 = 1; in_ren_2 = 1; in_raddr_2 = 2;
        tick();
        in_ren_1 = 0; in_ren_2 = 0;
        chk("ex_c3_op1", out_rdata_1, 32'h3);
        chk("ex_c3_op2", out_rdata_2, 32'h4);
        chk("ex_c3_v1",  {31'b0, out_rvalid_1}, 32'h1);
        tick();
        chk("ex_c4_op1", out_rdata_1, 32'h3);
        chk("ex_c4_op2", out_rdata_2, 32'h4);
        chk("ex_c4_v2",  {31'b0, out_rvalid_2}, 32'h0);
        in_wen = 1; in_waddr = 3; in_wdata = 32'h7;
        dbg(5'd3, 32'h0, "dbg_x3_precommit");
        tick();
        in_wen = 0;
        dbg(5'd3, 32'h7, "dbg_x3");

        // 6. Reset asserted mid-access
        in_wen = 1; in_waddr = 9; in_wdata = 32'h5;
        in_ren_1 = 1; in_raddr_1 = 1;
        #2;
        in_rst = 1'b0;
        #1;
        chk("midrst_rdata_1",  out_rdata_1, 32'h0);
        chk("midrst_rdata_2",  out_rdata_2, 32'h0);
        chk("midrst_rvalid_1", {31'b0, out_rvalid_1}, 32'h0);
        tick();
        chk("midrst_edge_rvalid_1", {31'b0, out_rvalid_1}, 32'h0);
        chk("midrst_edge_rdata_1",  out_rdata_1, 32'h0);
        dbg(5'd9, 32'h0, "midrst_dbg_x9");
        dbg(5'd1, 32'h0, "midrst_dbg_x1");
        in_wen = 0; in_ren_1 = 0;
        in_rst = 1'b1;
        tick();
        dbg(5'd9, 32'h0, "postrst_dbg_x9");
        chk("postrst_rvalid_1", {31'b0, out_rvalid_1}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
